regfile_dump_ctrl: RTL
======================

REGFILE_DUMP_CTRL -- requirements
Module: regfile_dump_ctrl

Interface
REQ-001 SHALL have parameter REGS, default 5, register address width.
REQ-002 SHALL have parameter NBITS, default 32, register data width; must be a multiple of 8.
REQ-003 SHALL have parameter TAM, default 32, number of registers dumped (addresses 0..TAM-1).
REQ-004 SHALL have port i_clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_start  input  1  level-sampled dump request; acted on only in IDLE.
REQ-007 SHALL have port o_RegDebug_sel  output  REGS  register-file debug read address.
REQ-008 SHALL have port i_RegDebug  input  NBITS  register-file debug read data, combinational from o_RegDebug_sel.
REQ-009 SHALL have port o_tx_data  output  8  byte for the serial transmitter.
REQ-010 SHALL have port o_tx_start  output  1  one-cycle transmit-start pulse.
REQ-011 SHALL have port i_tx_done  input  1  transmitter byte-complete pulse.
REQ-012 SHALL have port o_busy  output  1  high while a dump is in progress.
REQ-013 SHALL have port o_done  output  1  one-cycle pulse at dump completion.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, SEND, WAIT, DONE; all outputs registered.
REQ-015 IDLE: when i_start=1, SHALL set reg_idx=0, byte_idx=0, o_RegDebug_sel=0 and o_busy=1, then go to LOAD.
REQ-016 LOAD: SHALL capture i_RegDebug into an NBITS shift register (address already stable for one cycle), then go to SEND.
REQ-017 SEND: SHALL drive o_tx_data=shift[7:0] and assert o_tx_start for exactly one cycle, then go to WAIT.
REQ-018 WAIT: SHALL hold o_tx_data; on i_tx_done=1 with byte_idx<NBITS/8-1, SHALL shift right by 8, increment byte_idx and go to SEND.
REQ-019 WAIT: on i_tx_done=1 with last byte and reg_idx<TAM-1, SHALL increment reg_idx and o_RegDebug_sel, clear byte_idx and go to LOAD.
REQ-020 WAIT: on i_tx_done=1 with last byte and reg_idx=TAM-1, SHALL go to DONE.
REQ-021 DONE: SHALL pulse o_done for one cycle, clear o_busy and return to IDLE; the next dump requires i_start in IDLE.
REQ-022 Byte order SHALL be least-significant byte first within a register; registers SHALL be sent in ascending address order.
REQ-023 A complete dump SHALL emit exactly TAM*NBITS/8 o_tx_start pulses (128 at defaults).
REQ-024 i_start outside IDLE SHALL be ignored; a dump is never restarted or queued.
REQ-025 i_tx_done outside WAIT SHALL be ignored; no byte is skipped or repeated.
REQ-026 Minimum cycles per byte SHALL be 2 (SEND plus WAIT with i_tx_done in the same cycle); an extra LOAD cycle SHALL precede each register.
REQ-027 reg_idx and byte_idx SHALL never wrap; reg_idx saturates at TAM-1 and terminates via DONE.

Reset
REQ-028 i_reset=1 SHALL, asynchronously, force state IDLE and set o_RegDebug_sel=0, o_tx_data=0x00, o_tx_start=0, o_busy=0, o_done=0, shift register=0, and both indices=0.
REQ-029 Reset asserted mid-dump SHALL abort immediately without an o_done pulse; the first i_start after reset releases SHALL restart from register 0, byte 0.

Verification
REQ-030 Register file loaded with reg[i]=i, i_start pulse, i_tx_done 3 cycles after each o_tx_start -> 128 bytes in order 00 00 00 00, 01 00 00 00, ..., 1F 00 00 00; one o_done pulse; o_busy falls with o_done.
REQ-031 reg[5]=0xDEADBEEF, i_tx_done in the same cycle WAIT is entered -> bytes 21..24 are EF BE AD DE; 2 cycles per byte within a register; 1 extra LOAD cycle between registers.
REQ-032 i_start held high during the whole dump -> exactly 128 o_tx_start pulses before o_done; a new dump starts on the cycle after IDLE is re-entered.
REQ-033 Spurious i_tx_done during LOAD and SEND -> ignored; byte sequence and count are unchanged.
REQ-034 i_reset asserted after byte 50 -> all outputs reach reset values without a clock edge; no o_done pulse; a following i_start yields the full 128-byte sequence from reg 0.

Source files
------------

// File: rtl/regfile_dump_ctrl.sv
// Register-file dump controller: walks addresses 0..TAM-1, reads each register
// through the debug port and hands it to a byte-wide serial transmitter,
// least-significant byte first.
module regfile_dump_ctrl #(
  parameter int unsigned REGS  = 5,
  parameter int unsigned NBITS = 32,
  parameter int unsigned TAM   = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  output logic [REGS-1:0]  o_RegDebug_sel,
  input  logic [NBITS-1:0] i_RegDebug,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_start,
  input  logic             i_tx_done,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned NBytes = NBITS / 8;
  localparam int unsigned ByteW  = (NBytes > 1) ? $clog2(NBytes) : 1;

  localparam logic [ByteW-1:0] LastByte = ByteW'(NBytes - 1);
  localparam logic [REGS-1:0]  LastReg  = REGS'(TAM - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StWait,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [REGS-1:0]  reg_idx_q, reg_idx_d;
  logic [ByteW-1:0] byte_idx_q, byte_idx_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State and output registers; reset aborts any dump in progress.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StIdle;
      reg_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_idx_q  <= reg_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic. Pulses (tx_start, done) default low so they last one cycle.
  always_comb begin
    state_d    = state_q;
    reg_idx_d  = reg_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_start) begin
          reg_idx_d  = '0;
          byte_idx_d = '0;
          busy_d     = 1'b1;
          state_d    = StLoad;
        end
      end
      // Address has been stable for a full cycle, so read data is settled.
      StLoad: begin
        shift_d = i_RegDebug;
        state_d = StSend;
      end
      StSend: begin
        tx_data_d  = shift_q[7:0];
        tx_start_d = 1'b1;
        state_d    = StWait;
      end
      StWait: begin
        if (i_tx_done) begin
          if (byte_idx_q != LastByte) begin
            shift_d    = shift_q >> 8;
            byte_idx_d = byte_idx_q + ByteW'(1);
            state_d    = StSend;
          end else if (reg_idx_q != LastReg) begin
            reg_idx_d  = reg_idx_q + REGS'(1);
            byte_idx_d = '0;
            state_d    = StLoad;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign o_RegDebug_sel = reg_idx_q;
  assign o_tx_data      = tx_data_q;
  assign o_tx_start     = tx_start_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;

endmodule
